// File: rtl/cam_frame_writer.sv
// OV7670-style camera capture: synchronises href/vsync/data, packs sensor bytes into
// pixels and writes them, optionally 2x2-decimated, into a linear frame buffer.
module cam_frame_writer #(
   parameter int H_ACTIVE      = 320,
   parameter int V_ACTIVE      = 240,
   parameter int BYTES_PER_PIX = 2,
   parameter int ADDR_W        = 17
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       href,
   input  logic                       vsync,
   input  logic [7:0]                 ov7670_data,
   input  logic                       capture_en,
   input  logic                       single_shot,
   input  logic                       decim,
   output logic                       we,
   output logic [ADDR_W-1:0]          wAddr,
   output logic [8*BYTES_PER_PIX-1:0] wData,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       line_err,
   output logic [15:0]                frame_cnt
);

   localparam int                PW        = 8*BYTES_PER_PIX;
   localparam logic [ADDR_W-1:0] LAST_FULL = ADDR_W'(H_ACTIVE*V_ACTIVE - 1);
   localparam logic [ADDR_W-1:0] LAST_DEC  = ADDR_W'((H_ACTIVE/2)*(V_ACTIVE/2) - 1);
   localparam logic [ADDR_W-1:0] W_FULL    = ADDR_W'(H_ACTIVE);
   localparam logic [ADDR_W-1:0] W_DEC     = ADDR_W'(H_ACTIVE/2);

   typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

   state_t            state_q, state_d;
   logic              href_q1, href_s, vsync_q1, vsync_s, href_prev_q;
   logic [7:0]        data_q1, data_s;
   logic              decim_q, decim_d, single_q, single_d, shot_q, shot_d;
   logic              bcnt_q, bcnt_d;
   logic [7:0]        hi_q, hi_d;
   logic [15:0]       col_q, col_d, line_q, line_d;
   logic [ADDR_W-1:0] base_q, base_d, waddr_q, waddr_d;
   logic [PW-1:0]     wdata_q, wdata_d, pix_w;
   logic              we_q, we_d, line_err_q, line_err_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic              pix_last, col_ok, line_ok, keep;
   logic [ADDR_W-1:0] out_w, out_col, last_addr;

   generate
      if (BYTES_PER_PIX == 2) begin : g_two
         assign pix_w = {hi_q, data_s};
      end else begin : g_one
         assign pix_w = data_s;
      end
   endgenerate

   assign pix_last  = (BYTES_PER_PIX == 1) ? 1'b1 : bcnt_q;
   assign col_ok    = col_q < 16'(H_ACTIVE);
   assign line_ok   = line_q < 16'(V_ACTIVE);
   assign keep      = !decim_q || (!col_q[0] && !line_q[0]);
   assign out_w     = decim_q ? W_DEC : W_FULL;
   assign out_col   = ADDR_W'(col_q >> decim_q);
   assign last_addr = decim_q ? LAST_DEC : LAST_FULL;

   // After a single-shot frame, re-arming needs capture_en to drop first.
   always_comb begin
      state_d    = state_q;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         IDLE:    if (capture_en && vsync_s && !shot_q) state_d = ARM;
         ARM:     if (!vsync_s) state_d = CAPTURE;
         CAPTURE: begin
            busy = 1'b1;
            if (vsync_s || (we_q && waddr_q == last_addr)) state_d = DONE;
         end
         DONE: begin
            frame_done = 1'b1;
            state_d    = (single_q || !capture_en) ? IDLE : ARM;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      col_d       = col_q;
      line_d      = line_q;
      base_d      = base_q;
      bcnt_d      = bcnt_q;
      hi_d        = hi_q;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      line_err_d  = line_err_q;
      decim_d     = decim_q;
      single_d    = single_q;
      shot_d      = shot_q;
      frame_cnt_d = frame_cnt_q;
      if (!capture_en) shot_d = 1'b0;
      case (state_q)
         ARM: if (!vsync_s) begin
            decim_d    = decim;
            single_d   = single_shot;
            col_d      = '0;
            line_d     = '0;
            base_d     = '0;
            bcnt_d     = 1'b0;
            line_err_d = 1'b0;
         end
         CAPTURE: begin
            if (href_s) begin
               bcnt_d = ~bcnt_q;
               hi_d   = data_s;
               if (pix_last) begin
                  bcnt_d = 1'b0;
                  if (col_q != 16'hFFFF) col_d = col_q + 16'd1;
                  if (col_ok && line_ok && keep) begin
                     we_d    = 1'b1;
                     waddr_d = base_q + out_col;
                     wdata_d = pix_w;
                  end
               end
            end else begin
               // A trailing partial pixel is dropped simply by clearing the byte phase.
               bcnt_d = 1'b0;
               col_d  = '0;
               if (href_prev_q) begin
                  if (col_q != 16'(H_ACTIVE)) line_err_d = 1'b1;
                  if (line_q != 16'hFFFF) line_d = line_q + 16'd1;
                  if (!decim_q || line_q[0]) base_d = base_q + out_w;
               end
            end
         end
         DONE: begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (single_q) shot_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         href_q1     <= 1'b0;
         href_s      <= 1'b0;
         vsync_q1    <= 1'b0;
         vsync_s     <= 1'b0;
         data_q1     <= '0;
         data_s      <= '0;
         href_prev_q <= 1'b0;
         decim_q     <= 1'b0;
         single_q    <= 1'b0;
         shot_q      <= 1'b0;
         bcnt_q      <= 1'b0;
         hi_q        <= '0;
         col_q       <= '0;
         line_q      <= '0;
         base_q      <= '0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         line_err_q  <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         href_q1     <= href;
         href_s      <= href_q1;
         vsync_q1    <= vsync;
         vsync_s     <= vsync_q1;
         data_q1     <= ov7670_data;
         data_s      <= data_q1;
         href_prev_q <= href_s;
         decim_q     <= decim_d;
         single_q    <= single_d;
         shot_q      <= shot_d;
         bcnt_q      <= bcnt_d;
         hi_q        <= hi_d;
         col_q       <= col_d;
         line_q      <= line_d;
         base_q      <= base_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         line_err_q  <= line_err_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign we        = we_q;
   assign wAddr     = waddr_q;
   assign wData     = wdata_q;
   assign line_err  = line_err_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_cam_frame_writer.sv
// Scoreboard bench for cam_frame_writer on a scaled-down 16x8 sensor; pixel data encodes
// {line, column} so any address/data slip shows up in the monitor.
module tb_cam_frame_writer;
   localparam int H  = 16;
   localparam int V  = 8;
   localparam int AW = 7;

   logic          clk = 1'b0;
   logic          reset, href, vsync, capture_en, single_shot, decim;
   logic [7:0]    ov7670_data;
   logic          we, busy, frame_done, line_err;
   logic [AW-1:0] wAddr;
   logic [15:0]   wData, frame_cnt;

   int nvec   = 0;
   int nerr   = 0;
   int fd_cnt = 0;
   logic [AW+15:0] sb[$];

   cam_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .BYTES_PER_PIX(2), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .href(href), .vsync(vsync), .ov7670_data(ov7670_data),
      .capture_en(capture_en), .single_shot(single_shot), .decim(decim),
      .we(we), .wAddr(wAddr), .wData(wData), .busy(busy), .frame_done(frame_done),
      .line_err(line_err), .frame_cnt(frame_cnt));

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every write must match the head of the expected queue.
   always @(negedge clk) begin
      logic [AW+15:0] e;
      if (frame_done) fd_cnt++;
      if (we) begin
         nvec++;
         if (sb.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_write: got addr=%0d data=%h expected none", wAddr, wData);
         end else begin
            e = sb.pop_front();
            if ({wAddr, wData} !== e) begin
               nerr++;
               $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h",
                        wAddr, wData, e[AW+15:16], e[15:0]);
            end
         end
      end
   end

   function automatic int line_len(input bit odd, input int l);
      if (odd && l == 5) return H + 2;
      if (odd && l == 6) return H - 2;
      return H;
   endfunction

   task automatic rearm();
      capture_en = 1'b0;
      repeat (2) tick();
      capture_en = 1'b1;
      tick();
   endtask

   task automatic vs_pulse();
      vsync = 1'b1;
      repeat (6) tick();
      vsync = 1'b0;
      repeat (6) tick();
   endtask

   task automatic send_frame(input int nlines, input int ed, input bit push, input bit odd,
                             input int tog_line, input int cen_line, input int rst_line,
                             input bit chk_idle, input bit chk_err);
      bit pushing;
      int a;
      pushing = push;
      vs_pulse();
      for (int l = 0; l < nlines; l++) begin
         if (l == rst_line) begin
            reset = 1'b1;
            tick();
            chk("rst_mid_we", we, 0);
            chk("rst_mid_busy", busy, 0);
            chk("rst_mid_fcnt", frame_cnt, 0);
            reset   = 1'b0;
            pushing = 1'b0;
         end
         if (l == tog_line) decim = ~decim;
         if (l == cen_line) capture_en = 1'b0;
         for (int c = 0; c < line_len(odd, l); c++) begin
            if (pushing && c < H && l < V && (ed == 0 || (c % 2 == 0 && l % 2 == 0))) begin
               a = (l >> ed) * (H >> ed) + (c >> ed);
               sb.push_back({AW'(a), 8'(l), 8'(c)});
            end
            href        = 1'b1;
            ov7670_data = 8'(l);
            tick();
            ov7670_data = 8'(c);
            tick();
         end
         href = 1'b0;
         repeat (8) tick();
         if (chk_idle) chk("single_busy", busy, 0);
         if (chk_err) chk("line_err_seq", line_err, (l >= 5) ? 1 : 0);
      end
      repeat (8) tick();
   endtask

   initial begin
      reset = 1'b1; href = 1'b0; vsync = 1'b0; ov7670_data = 8'h00;
      capture_en = 1'b0; single_shot = 1'b0; decim = 1'b0;
      repeat (3) tick();
      chk("rst_we", we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fd", frame_done, 0);
      chk("rst_lerr", line_err, 0);
      chk("rst_fcnt", frame_cnt, 0);
      chk("rst_addr", wAddr, 0);
      chk("rst_data", wData, 0);
      reset = 1'b0;
      tick();

      // Full-size frame
      capture_en = 1'b1; single_shot = 1'b1; decim = 1'b0;
      send_frame(V, 0, 1, 0, -1, -1, -1, 0, 0);
      chk("full_drain", sb.size(), 0);
      chk("full_fcnt", frame_cnt, 1);
      chk("full_fd", fd_cnt, 1);
      chk("full_lerr", line_err, 0);
      chk("full_busy", busy, 0);

      // Decimated frame: line 2 starts at 8, last write at 31
      rearm(); decim = 1'b1;
      send_frame(V, 1, 1, 0, -1, -1, -1, 0, 0);
      chk("dec_drain", sb.size(), 0);
      chk("dec_fcnt", frame_cnt, 2);
      chk("dec_fd", fd_cnt, 2);

      // Long line 5, short line 6
      rearm(); decim = 1'b0;
      send_frame(V, 0, 1, 1, -1, -1, -1, 0, 1);
      chk("len_drain", sb.size(), 0);
      chk("len_fcnt", frame_cnt, 3);

      // Single shot across three frames
      rearm();
      send_frame(V, 0, 1, 0, -1, -1, -1, 0, 0);
      send_frame(V, 0, 0, 0, -1, -1, -1, 1, 0);
      send_frame(V, 0, 0, 0, -1, -1, -1, 1, 0);
      chk("ss_drain", sb.size(), 0);
      chk("ss_fd", fd_cnt, 4);
      chk("ss_fcnt", frame_cnt, 4);
      chk("ss_lerr_clr", line_err, 0);

      // Reset mid-frame, then a clean frame from address 0
      rearm();
      send_frame(V, 0, 1, 0, -1, -1, 3, 0, 0);
      chk("abort_drain", sb.size(), 0);
      send_frame(V, 0, 1, 0, -1, -1, -1, 0, 0);
      chk("post_rst_drain", sb.size(), 0);
      chk("post_rst_fcnt", frame_cnt, 1);
      chk("post_rst_fd", fd_cnt, 5);

      // decim toggled mid-frame; capture_en dropped mid-frame does not abort
      rearm(); single_shot = 1'b0; decim = 1'b0;
      send_frame(V, 0, 1, 0, 3, 4, -1, 0, 0);
      chk("tog_a_drain", sb.size(), 0);
      chk("tog_a_fcnt", frame_cnt, 2);
      chk("tog_a_busy", busy, 0);
      capture_en = 1'b1; single_shot = 1'b1;
      send_frame(V, 1, 1, 0, 3, -1, -1, 0, 0);
      chk("tog_b_drain", sb.size(), 0);
      chk("tog_b_fcnt", frame_cnt, 3);
      chk("tog_b_fd", fd_cnt, 7);

      // Short frame terminated by the next vsync
      rearm(); decim = 1'b0;
      send_frame(4, 0, 1, 0, -1, -1, -1, 0, 0);
      chk("short_busy", busy, 1);
      vs_pulse();
      chk("short_fd", fd_cnt, 8);
      chk("short_fcnt", frame_cnt, 4);
      chk("short_idle", busy, 0);
      chk("short_drain", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
